// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and count width for the counter and its monitor
package counter_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNCING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

endpackage

// File: rtl/counter_seq_monitor_if.sv
// rtl/counter_seq_monitor_if.sv - sample/control inputs and status outputs of the sequence monitor
interface counter_seq_monitor_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              en;
    logic [WIDTH-1:0]  cnt_in;
    logic              clr_err;
    logic              locked;
    logic              err;
    logic              err_pulse;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output en, cnt_in, clr_err,
        input  locked, err, err_pulse, wrap_pulse, wrap_count, err_count
    );

    modport slave (
        input  en, cnt_in, clr_err,
        output locked, err, err_pulse, wrap_pulse, wrap_count, err_count
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] MAX = '1;

    // A clear coinciding with a new event keeps that event, so the count restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && count != MAX) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/counter_seq_monitor.sv
// rtl/counter_seq_monitor.sv - checks that a count bus advances by one per enabled sample
module counter_seq_monitor
    import counter_pkg::*;
#(
    parameter int WIDTH    = CNT_W,
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4
) (
    input  logic clk,
    input  logic rst,
    counter_seq_monitor_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V  = '1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_LEN);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  exp_v;
    logic [3:0]        run_q, run_d;
    logic              match;
    logic              mismatch;
    logic              wrap;
    logic              locked_q, err_q, err_pulse_q, wrap_pulse_q;
    logic [WRAP_W-1:0] wrap_count_q;

    assign exp_v = prev_q + WIDTH'(1);
    assign match = (bus.cnt_in == exp_v);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        mismatch = 1'b0;
        wrap     = 1'b0;
        if (bus.en) begin
            case (state_q)
                UNLOCKED: begin
                    run_d   = '0;
                    state_d = SYNCING;
                end
                SYNCING: begin
                    if (match) begin
                        run_d = run_q + 4'd1;
                        if (run_d == LOCK_N) state_d = LOCKED;
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        mismatch = 1'b1;
                        run_d    = '0;
                        state_d  = SYNCING;
                    end else if (prev_q == MAX_V) begin
                        // A correct increment from the maximum value is necessarily max->0.
                        wrap = 1'b1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= UNLOCKED;
            prev_q       <= '0;
            run_q        <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            locked_q     <= (state_d == LOCKED);
            err_pulse_q  <= mismatch;
            wrap_pulse_q <= wrap;
            if (bus.en) prev_q <= bus.cnt_in;
            if (wrap) wrap_count_q <= wrap_count_q + WRAP_W'(1);
            if (mismatch) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch),
        .clr   (bus.clr_err),
        .count (bus.err_count)
    );

    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_count = wrap_count_q;
endmodule

// File: tb/tb_counter_seq_monitor.sv
// tb/tb_counter_seq_monitor.sv - scoreboard bench for counter_seq_monitor
module tb_counter_seq_monitor;
    logic clk;
    logic rst;

    counter_seq_monitor_if #(.WIDTH(3), .WRAP_W(8), .ERR_W(4)) bus ();

    counter_seq_monitor #(.WIDTH(3), .LOCK_LEN(4), .WRAP_W(8), .ERR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   p;
    int   wc_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] pack(input bit l, input bit e, input bit ep, input bit wp,
                                         input int wc, input int ec);
        return {l, e, ep, wp, 8'(wc), 4'(ec)};
    endfunction

    function automatic logic [15:0] actual();
        return {bus.locked, bus.err, bus.err_pulse, bus.wrap_pulse, bus.wrap_count, bus.err_count};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got l/e/ep/wp/wc/ec=%0b/%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0b/%0d/%0d",
                     name, act[15], act[14], act[13], act[12], act[11:4], act[3:0],
                     req[15], req[14], req[13], req[12], req[11:4], req[3:0]);
        end
    endtask

    // Drive one sample, queue its expected post-edge outputs, return at the following negedge.
    task automatic step(input bit en, input int cnt, input bit clr,
                        input bit l, input bit e, input bit ep, input bit wp,
                        input int wc, input int ec, input string name);
        exp_t x;
        bus.en      = en;
        bus.cnt_in  = 3'(cnt);
        bus.clr_err = clr;
        @(posedge clk);
        x.v    = pack(l, e, ep, wp, wc, ec);
        x.name = name;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Repeat the current value (mismatch), then relock with four increments.
    task automatic miss_relock(input bit clr, input int ec_e, input int wc_k);
        step(1, p, clr, 0, 1, 1, 0, wc_k, ec_e, "miss");
        for (int j = 1; j <= 4; j++)
            step(1, (p + j) % 8, 0, (j == 4), 1, 0, 0, wc_k, ec_e, "relock");
        p = (p + 4) % 8;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                check(x.name, actual(), x.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int vals[12];
        bus.en = 0; bus.cnt_in = 0; bus.clr_err = 0;
        rst = 1'b0;
        #3 check("reset_state", actual(), 16'h0);
        #9 rst = 1'b1;
        @(negedge clk);

        // Lock on 0..5: locked after the edge sampling 4
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "lock0");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "lock1");
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, "lock2");
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, "lock3");
        step(1, 4, 0, 1, 0, 0, 0, 0, 0, "lock4");
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, "lock5");

        // Two full wraps while locked
        vals = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        wc_e = 0;
        foreach (vals[i]) begin
            if (vals[i] == 0) wc_e++;
            step(1, vals[i], 0, 1, 0, 0, (vals[i] == 0), wc_e, 0, "wrap");
        end

        // Skip 4: error, then relock on 5 with the 7->0 wrap uncounted
        step(1, 2, 0, 1, 0, 0, 0, 2, 0, "skip2");
        step(1, 3, 0, 1, 0, 0, 0, 2, 0, "skip3");
        step(1, 5, 0, 0, 1, 1, 0, 2, 1, "skip_err");
        step(1, 6, 0, 0, 1, 0, 0, 2, 1, "resync6");
        step(1, 7, 0, 0, 1, 0, 0, 2, 1, "resync7");
        step(1, 0, 0, 0, 1, 0, 0, 2, 1, "resync_wrap");
        step(1, 1, 0, 1, 1, 0, 0, 2, 1, "relock1");

        // Held value is a mismatch
        step(1, 2, 0, 1, 1, 0, 0, 2, 1, "hold2");
        step(1, 3, 0, 1, 1, 0, 0, 2, 1, "hold3");
        step(1, 3, 0, 0, 1, 1, 0, 2, 2, "hold_err");
        step(1, 4, 0, 0, 1, 0, 0, 2, 2, "hold_rs4");
        step(1, 5, 0, 0, 1, 0, 0, 2, 2, "hold_rs5");
        step(1, 6, 0, 0, 1, 0, 0, 2, 2, "hold_rs6");
        step(1, 7, 0, 1, 1, 0, 0, 2, 2, "hold_lock");
        step(1, 0, 0, 1, 1, 0, 1, 3, 2, "hold_wrap");
        step(1, 1, 0, 1, 1, 0, 0, 3, 2, "hold_1");
        step(1, 2, 0, 1, 1, 0, 0, 3, 2, "hold_2b");
        step(1, 3, 0, 1, 1, 0, 0, 3, 2, "hold_3b");

        // Enable gating: jump to 6 while disabled, resume with the expected 4
        for (int i = 0; i < 5; i++)
            step(0, 6, 0, 1, 1, 0, 0, 3, 2, "en_low");
        step(1, 4, 0, 1, 1, 0, 0, 3, 2, "en_resume");

        // Twenty more mismatches saturate err_count at 15
        p = 4;
        for (int k = 1; k <= 20; k++)
            miss_relock(0, (2 + k > 15) ? 15 : 2 + k, 3);

        // Clear alone, build err_count to 3, then clear colliding with a mismatch
        step(1, 5, 1, 1, 0, 0, 0, 3, 0, "clr_alone");
        p = 5;
        for (int k = 1; k <= 3; k++)
            miss_relock(0, k, 3);
        miss_relock(1, 1, 3);
        step(1, 6, 1, 1, 0, 0, 0, 3, 0, "clr_locked");

        // Two more wraps to reach wrap_count=5
        wc_e = 3;
        for (int i = 1; i <= 16; i++) begin
            if ((6 + i) % 8 == 0) wc_e++;
            step(1, (6 + i) % 8, 0, 1, 0, 0, ((6 + i) % 8 == 0), wc_e, 0, "wrap_to5");
        end

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1 check("async_reset", actual(), 16'h0);
        #1 rst = 1'b1;
        @(negedge clk);
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, "post_base");
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, "post_1");
        step(1, 4, 0, 0, 0, 0, 0, 0, 0, "post_2");
        step(1, 5, 0, 0, 0, 0, 0, 0, 0, "post_3");
        step(1, 6, 0, 1, 0, 0, 0, 0, 0, "post_lock");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_seq_monitor.md
Name: counter_seq_monitor

Overview:
- Downstream checker for the 3-bit up counter.
- Samples the counter's `out` bus every enabled clock and confirms each value is the previous value plus 1, modulo 2^WIDTH.
- Reports lock status, sticky and pulsed sequence errors, and counts wrap-arounds.
- Sits beside the counter in the counter test/demo harness as a self-checking consumer.

Parameters:
- WIDTH, 3: width of the monitored count bus.
- LOCK_LEN, 4: consecutive correct increments needed to declare lock (1..15).
- WRAP_W, 8: width of the wrap counter.
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when 0, nothing is sampled and all state holds.
- cnt_in  input  WIDTH  count value from the upstream counter.
- clr_err  input  1  synchronous clear of err and err_count.
- locked  output  1  sequence currently tracked and verified.
- err  output  1  sticky error flag.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- wrap_pulse  output  1  one-cycle pulse per verified max→0 transition.
- wrap_count  output  WRAP_W  verified wraps since reset, modulo 2^WRAP_W.
- err_count  output  ERR_W  mismatches since last clear, saturating at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=UNLOCKED; prev=0; run=0.
  - locked=0, err=0, err_pulse=0, wrap_pulse=0, wrap_count=0, err_count=0.
  - Takes effect immediately, including mid-sequence.
- Outputs are registered. Latency is one cycle from the sampled edge to the flag.
- exp = prev+1, truncated to WIDTH bits, so max+1 = 0.
- States:
  - UNLOCKED, on en: prev←cnt_in; run←0; go to SYNCING. No error is possible in this state.
  - SYNCING, on en:
    - cnt_in==exp: run←run+1. If run+1==LOCK_LEN, go to LOCKED and set locked=1 on that edge.
    - Otherwise: run←0 and stay in SYNCING. No error is flagged, since the sequence is not yet trusted.
    - prev←cnt_in in both cases.
  - LOCKED, on en:
    - cnt_in==exp: stay in LOCKED.
    - Otherwise: err_pulse=1; err←1; err_count increments, saturating; locked←0; run←0; go to SYNCING. A held (repeated) value is a mismatch.
    - prev←cnt_in in both cases.
- Wrap detection:
  - wrap_pulse=1 only when state is LOCKED, en=1, prev=2^WIDTH-1 and cnt_in=0.
  - On that edge wrap_count←wrap_count+1, rolling over silently.
  - A wrap on the same edge that completes lock (SYNCING→LOCKED) is not counted.
- en=0: state, prev, run, the counters and locked all hold; err_pulse=0 and wrap_pulse=0.
- clr_err=1: err←0 and err_count←0 on that edge.
  - If a mismatch is detected on the same edge, the error wins: err=1, err_count=1, err_pulse=1.
  - clr_err does not affect the state or locked.
- err_pulse and wrap_pulse are mutually exclusive by construction.

Decomposition:
- Shared package counter_pkg holds:
  - state enum: UNLOCKED=2'd0, SYNCING=2'd1, LOCKED=2'd2.
  - default WIDTH constant CNT_W=3, used by both the counter and this monitor.
- Natural sub-module: sat_counter, a saturating increment/clear counter of width ERR_W, used for err_count.
- The FSM and wrap logic stay in the top module.

Test Plan:
- Reset then lock:
  - Stimulus: hold rst=0 for 10 ns, release; en=1; drive 0,1,2,3,4,5.
  - Required: locked=1 one cycle after the edge that samples 4 (4th correct increment); err=0; err_count=0.
- Wrap:
  - Stimulus: while locked, drive ...,6,7,0,1 twice around the full sequence.
  - Required: wrap_pulse high one cycle after each 7→0 sample; wrap_count=2 at the end; no err_pulse.
- Skip error:
  - Stimulus: while locked, drive 2,3,5,6,7,0,1.
  - Required:
    - err_pulse one cycle after 5 is sampled; err=1; err_count=1; locked=0.
    - Relock with 5 as base: locked=1 after 1 is sampled (6,7,0,1).
    - The 7→0 wrap during SYNCING does not increment wrap_count.
- Hold, enable gating and error saturation:
  - Stimulus:
    - While locked, repeat value 3 for one sample: err_pulse expected.
    - Drop en for 5 cycles while cnt_in jumps to 6; raise en while driving 4: no error, state preserved.
    - Force 20 more mismatches, relocking between each.
  - Required: err_count saturates at 15.
- Clear collision:
  - Stimulus: with err=1, err_count=3, assert clr_err on the same edge as a new mismatch.
  - Required: err=1, err_count=1, err_pulse=1.
  - Then clr_err alone gives err=0, err_count=0, with locked unchanged.
- Async reset mid-operation:
  - Stimulus: while locked with wrap_count=5, assert rst low between clock edges.
  - Required: all outputs read 0 before the next rising edge; after release, relock requires LOCK_LEN fresh increments.
